uart_rx_param: RTL and testbench



---
 rtl/uart_rx_param_if.sv | 29 ++
 rtl/uart_rx_param.sv | 188 ++++++++++++++++++
 tb/tb_uart_rx_param.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if: receive-side word handshake between the UART receiver
// and the register/FIFO layer.
//   rx_data    : received word, LSB first on the line
//   rx_valid   : a word is held in rx_data
//   rx_ready   : consumer accepts the held word (transfer on valid & ready)
//   frame_err  : held word had a low stop bit
//   parity_err : held word failed its parity check
//   overrun    : one-cycle pulse when a completed frame is dropped
// master = receiver side, slave = consumer side.
interface uart_rx_param_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              frame_err;
  logic              parity_err;
  logic              overrun;

  modport master (
    output rx_data, rx_valid, frame_err, parity_err, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, parity_err, overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised oversampling UART receiver.
//   clk         : system clock
//   rst         : asynchronous active-low reset
//   rx_en       : receiver enable; dropping it mid-frame aborts the frame
//   baud_div    : clk cycles per oversample tick, minus 1 (latched per frame)
//   stop2       : 1 selects two stop bits (latched per frame)
//   parity_mode : 00 none, 01 even, 10 odd, 11 none (latched per frame)
//   rx_in       : asynchronous serial input, idles high
//   busy        : a frame is in progress
//   rx_if       : word handshake (rx_data/rx_valid/rx_ready + error flags)
// Build option: define UART_RX_PARITY_EN to compile in the parity state and
// checker. Without it parity_mode is ignored, parity_err is tied 0 and a
// parity bit on the line is sampled as the first stop bit.
module uart_rx_param #(
  parameter int DATA_W = 8,
  parameter int OVS    = 16,
  parameter int DIV_W  = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_en,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             stop2,
  input  logic [1:0]       parity_mode,
  input  logic             rx_in,
  output logic             busy,
  uart_rx_param_if.master  rx_if
);
  localparam int CNT_W = $clog2(OVS);
  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVS / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVS - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t             state_reg;
  logic               rx_s1_reg, rx_s2_reg, rx_d_reg;
  logic [DIV_W-1:0]   div_cnt_reg, div_last_reg;
  logic [CNT_W-1:0]   ovs_cnt_reg;
  logic [BIT_W-1:0]   bit_idx_reg;
  logic [DATA_W-1:0]  shift_reg;
  logic               stop2_reg;
  logic               ferr_acc_reg;
  logic [DATA_W-1:0]  rx_data_reg;
  logic               rx_valid_reg, frame_err_reg, overrun_reg;
`ifdef UART_RX_PARITY_EN
  logic               par_en_reg, par_odd_reg, perr_acc_reg, parity_err_reg;
`endif

  logic tick, sample, fall, can_load;

  always_comb begin
    tick     = (state_reg != IDLE) && (div_cnt_reg == div_last_reg);
    // START samples half a bit in (bit centre); later bits one full bit apart.
    sample   = tick && (ovs_cnt_reg == ((state_reg == START) ? HALF_LAST : FULL_LAST));
    fall     = rx_d_reg & ~rx_s2_reg;
    // A completing frame may load if the slot is empty or being emptied now.
    can_load = ~rx_valid_reg | rx_if.rx_ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      rx_s1_reg     <= 1'b1;
      rx_s2_reg     <= 1'b1;
      rx_d_reg      <= 1'b1;
      div_cnt_reg   <= '0;
      div_last_reg  <= '0;
      ovs_cnt_reg   <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      stop2_reg     <= 1'b0;
      ferr_acc_reg  <= 1'b0;
      rx_data_reg   <= '0;
      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_en_reg     <= 1'b0;
      par_odd_reg    <= 1'b0;
      perr_acc_reg   <= 1'b0;
      parity_err_reg <= 1'b0;
`endif
    end else begin
      rx_s1_reg   <= rx_in;
      rx_s2_reg   <= rx_s1_reg;
      rx_d_reg    <= rx_s2_reg;
      overrun_reg <= 1'b0;
      if (rx_valid_reg && rx_if.rx_ready)
        rx_valid_reg <= 1'b0;

      if (state_reg != IDLE && !rx_en) begin
        state_reg <= IDLE;
      end else if (state_reg == IDLE) begin
        div_cnt_reg  <= '0;
        ovs_cnt_reg  <= '0;
        bit_idx_reg  <= '0;
        ferr_acc_reg <= 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_acc_reg <= 1'b0;
`endif
        if (fall && rx_en) begin
          div_last_reg <= baud_div;
          stop2_reg    <= stop2;
`ifdef UART_RX_PARITY_EN
          par_en_reg   <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
          par_odd_reg  <= (parity_mode == 2'b10);
`endif
          state_reg    <= START;
        end
      end else if (!tick) begin
        div_cnt_reg <= div_cnt_reg + 1'b1;
      end else begin
        div_cnt_reg <= '0;
        if (!sample) begin
          ovs_cnt_reg <= ovs_cnt_reg + 1'b1;
        end else begin
          ovs_cnt_reg <= '0;
          case (state_reg)
            START: state_reg <= rx_s2_reg ? IDLE : DATA;
            DATA: begin
              shift_reg <= {rx_s2_reg, shift_reg[DATA_W-1:1]};
              if (bit_idx_reg == DATA_LAST) begin
                bit_idx_reg <= '0;
`ifdef UART_RX_PARITY_EN
                state_reg   <= par_en_reg ? PARITY : STOP;
`else
                state_reg   <= STOP;
`endif
              end else begin
                bit_idx_reg <= bit_idx_reg + 1'b1;
              end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
              // Error when XOR of data and parity bit differs from the mode's target.
              perr_acc_reg <= (^shift_reg) ^ rx_s2_reg ^ par_odd_reg;
              state_reg    <= STOP;
            end
`endif
            STOP: begin
              if (!rx_s2_reg)
                ferr_acc_reg <= 1'b1;
              if (bit_idx_reg == {{(BIT_W-1){1'b0}}, stop2_reg}) begin
                state_reg <= IDLE;
                if (can_load) begin
                  rx_data_reg    <= shift_reg;
                  rx_valid_reg   <= 1'b1;
                  frame_err_reg  <= ferr_acc_reg | ~rx_s2_reg;
`ifdef UART_RX_PARITY_EN
                  parity_err_reg <= perr_acc_reg;
`endif
                end else begin
                  overrun_reg <= 1'b1;
                end
              end else begin
                bit_idx_reg <= bit_idx_reg + 1'b1;
              end
            end
            default: state_reg <= IDLE;
          endcase
        end
      end
    end
  end

  assign busy             = (state_reg != IDLE);
  assign rx_if.rx_data    = rx_data_reg;
  assign rx_if.rx_valid   = rx_valid_reg;
  assign rx_if.frame_err  = frame_err_reg;
  assign rx_if.overrun    = overrun_reg;
`ifdef UART_RX_PARITY_EN
  assign rx_if.parity_err = parity_err_reg;
`else
  logic unused_parity_mode;
  assign unused_parity_mode = ^parity_mode;
  assign rx_if.parity_err   = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param (DATA_W=8, OVS=16). Directed vector
// table, hand-written corner sequences and random frames checked against a
// frame-level reference model.
module tb_uart_rx_param;
  localparam int OVS = 16;

  logic        clk = 1'b0;
  logic        rst, rx_en, stop2, rx_in, busy;
  logic [19:0] baud_div;
  logic [1:0]  parity_mode;

  uart_rx_param_if #(.DATA_W(8)) rx_if();

  uart_rx_param #(.DATA_W(8), .OVS(OVS), .DIV_W(20)) dut (
    .clk(clk), .rst(rst), .rx_en(rx_en), .baud_div(baud_div), .stop2(stop2),
    .parity_mode(parity_mode), .rx_in(rx_in), .busy(busy), .rx_if(rx_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int c0       = 0;
  int ov_cnt   = 0;

  typedef struct {
    logic [7:0] data;
    logic       fe;
    logic       pe;
    int         cyc;
  } word_t;
  word_t got_q[$];

  // Monitor: record each newly presented word and count overrun pulses.
  logic prev_valid = 1'b0, prev_acc = 1'b0;
  always @(negedge clk) begin
    if (rx_if.rx_valid && (!prev_valid || prev_acc)) begin
      got_q.push_back('{rx_if.rx_data, rx_if.frame_err, rx_if.parity_err, cyc});
      $display("rx word 0x%02h frame_err=%0b parity_err=%0b at cycle %0d",
               rx_if.rx_data, rx_if.frame_err, rx_if.parity_err, cyc);
    end
    if (rx_if.overrun) ov_cnt <= ov_cnt + 1;
    prev_valid <= rx_if.rx_valid;
    prev_acc   <= rx_if.rx_valid & rx_if.rx_ready;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Clocks from line fall to rx_valid visible: 2 sync + 1 detect, then
  // half a bit plus (8 data + ns extra samples) full bits of ticks.
  function automatic int lat(input int bdiv, input int ns);
    return 3 + (bdiv + 1) * (OVS / 2 + OVS * (8 + ns));
  endfunction

  // Frame-level reference: tail holds line bits after the data, in order.
  function automatic void model(input logic [7:0] d, input logic [1:0] pm, input logic s2,
                                input logic [3:0] tail, output logic fe, output logic pe,
                                output int ns, output int ntail);
    logic par_sent;
    int   pos;
    par_sent = (pm == 2'b01) || (pm == 2'b10);
    ntail = (par_sent ? 1 : 0) + (s2 ? 2 : 1);
    pos = 0;
    fe  = 1'b0;
    pe  = 1'b0;
`ifdef UART_RX_PARITY_EN
    if (par_sent) begin
      pe  = (((^d) ^ tail[0]) != (pm == 2'b10));
      pos = 1;
    end
`endif
    for (int i = 0; i < (s2 ? 2 : 1); i++)
      if (!tail[pos + i]) fe = 1'b1;
    ns = pos + (s2 ? 2 : 1);
  endfunction

  task automatic send_line(input logic [7:0] d, input logic [3:0] tail, input int ntail,
                           input int bdiv);
    int bp;
    bp = OVS * (bdiv + 1);
    baud_div = 20'(bdiv);
    rx_in = 1'b0;
    c0 = cyc;
    repeat (bp) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      repeat (bp) @(negedge clk);
    end
    for (int i = 0; i < ntail; i++) begin
      rx_in = tail[i];
      repeat (bp) @(negedge clk);
    end
    rx_in = 1'b1;
    repeat (2 * bp) @(negedge clk);
  endtask

  task automatic expect_word(input string name, input logic [7:0] ed, input logic efe,
                             input logic epe, input int el);
    word_t w;
    chk({name, " count"}, 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) begin
      w = got_q.pop_front();
      chk({name, " data"}, 32'(w.data), 32'(ed));
      chk({name, " frame_err"}, 32'(w.fe), 32'(efe));
      chk({name, " parity_err"}, 32'(w.pe), 32'(epe));
      chk({name, " latency"}, 32'(w.cyc - c0), 32'(el));
    end
    got_q.delete();
  endtask

  typedef struct {
    string      name;
    logic [7:0] data;
    logic [1:0] pmode;
    logic       s2;
    logic [3:0] tail;
    int         ntail;
    int         bdiv;
    logic [7:0] exp_data;
    logic       exp_fe;
    logic       exp_pe;
    int         nsamp;
  } vec_t;
  vec_t vecs[$];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bp, ov0;
    rst = 1'b0; rx_en = 1'b1; stop2 = 1'b0; parity_mode = 2'b00;
    rx_in = 1'b1; baud_div = '0; rx_if.rx_ready = 1'b1;

    vecs.push_back('{"8N1 A5",      8'hA5, 2'b00, 1'b0, 4'b0001, 1, 0, 8'hA5, 1'b0, 1'b0, 1});
    vecs.push_back('{"low stop 3C", 8'h3C, 2'b00, 1'b0, 4'b0000, 1, 0, 8'h3C, 1'b1, 1'b0, 1});
    vecs.push_back('{"stop2 bad",   8'h00, 2'b00, 1'b1, 4'b0001, 2, 0, 8'h00, 1'b1, 1'b0, 2});
    vecs.push_back('{"stop2 good",  8'hFF, 2'b00, 1'b1, 4'b0011, 2, 0, 8'hFF, 1'b0, 1'b0, 2});
    vecs.push_back('{"div2 5A",     8'h5A, 2'b00, 1'b0, 4'b0001, 1, 2, 8'h5A, 1'b0, 1'b0, 1});
`ifdef UART_RX_PARITY_EN
    vecs.push_back('{"even p0",     8'h07, 2'b01, 1'b0, 4'b0010, 2, 0, 8'h07, 1'b0, 1'b1, 2});
    vecs.push_back('{"even p1",     8'h07, 2'b01, 1'b0, 4'b0011, 2, 0, 8'h07, 1'b0, 1'b0, 2});
    vecs.push_back('{"odd p0",      8'h07, 2'b10, 1'b0, 4'b0010, 2, 0, 8'h07, 1'b0, 1'b0, 2});
`else
    // Parity bit 0 on the line lands on the stop sample.
    vecs.push_back('{"par as stop", 8'h07, 2'b01, 1'b0, 4'b0010, 2, 0, 8'h07, 1'b1, 1'b0, 1});
`endif

    repeat (3) @(negedge clk);
    chk("reset rx_valid", 32'(rx_if.rx_valid), 32'd0);
    chk("reset rx_data", 32'(rx_if.rx_data), 32'd0);
    chk("reset frame_err", 32'(rx_if.frame_err), 32'd0);
    chk("reset parity_err", 32'(rx_if.parity_err), 32'd0);
    chk("reset overrun", 32'(rx_if.overrun), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    foreach (vecs[i]) begin
      stop2 = vecs[i].s2;
      parity_mode = vecs[i].pmode;
      send_line(vecs[i].data, vecs[i].tail, vecs[i].ntail, vecs[i].bdiv);
      expect_word(vecs[i].name, vecs[i].exp_data, vecs[i].exp_fe, vecs[i].exp_pe,
                  lat(vecs[i].bdiv, vecs[i].nsamp));
    end
    stop2 = 1'b0; parity_mode = 2'b00; baud_div = '0; bp = OVS;

    // 4-clk glitch: START sample sees a high line and abandons the frame.
    rx_in = 1'b0;
    repeat (4) @(negedge clk);
    chk("glitch busy rises", 32'(busy), 32'd1);
    rx_in = 1'b1;
    repeat (16) @(negedge clk);
    chk("glitch busy clear", 32'(busy), 32'd0);
    chk("glitch no word", 32'(got_q.size()), 32'd0);

    // Low stop bit, line held low 40 more clk, then high: exactly one word.
    rx_in = 1'b0; c0 = cyc;
    repeat (bp) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = (8'h3C >> i) & 1'b1;
      repeat (bp) @(negedge clk);
    end
    rx_in = 1'b0;
    repeat (bp + 40) @(negedge clk);
    rx_in = 1'b1;
    repeat (3 * bp) @(negedge clk);
    expect_word("held low", 8'h3C, 1'b1, 1'b0, lat(0, 1));
    chk("held low busy", 32'(busy), 32'd0);

    // Random frames against the reference model.
    for (int r = 0; r < 20; r++) begin
      logic [7:0] d;
      logic [1:0] pm;
      logic       s2, efe, epe;
      logic [3:0] tail;
      int         bd, ns, nt;
      d  = 8'($urandom);
      pm = 2'($urandom);
      s2 = 1'($urandom);
      bd = $urandom_range(0, 2);
      for (int i = 0; i < 4; i++) tail[i] = ($urandom_range(0, 5) != 0);
      if (pm == 2'b01 || pm == 2'b10) tail[0] = 1'($urandom);
      model(d, pm, s2, tail, efe, epe, ns, nt);
      // Bits past the last sample stay high so they cannot start a new frame.
      for (int i = 0; i < 4; i++) if (i >= ns) tail[i] = 1'b1;
      stop2 = s2;
      parity_mode = pm;
      send_line(d, tail, nt, bd);
      expect_word($sformatf("rand%0d", r), d, efe, epe, lat(bd, ns));
    end
    stop2 = 1'b0; parity_mode = 2'b00;

    // Overrun: consumer stalled, second frame dropped.
    rx_if.rx_ready = 1'b0;
    ov0 = ov_cnt;
    send_line(8'h11, 4'b0001, 1, 0);
    expect_word("ovr first", 8'h11, 1'b0, 1'b0, lat(0, 1));
    send_line(8'h22, 4'b0001, 1, 0);
    chk("ovr no new word", 32'(got_q.size()), 32'd0);
    chk("ovr pulse count", 32'(ov_cnt - ov0), 32'd1);
    chk("ovr data held", 32'(rx_if.rx_data), 32'h11);
    chk("ovr valid held", 32'(rx_if.rx_valid), 32'd1);
    rx_if.rx_ready = 1'b1;
    @(negedge clk);
    chk("ready clears valid", 32'(rx_if.rx_valid), 32'd0);

    // rx_en dropped mid-frame aborts without loading.
    rx_in = 1'b0;
    repeat (3 * bp) @(negedge clk);
    rx_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort busy", 32'(busy), 32'd0);
    repeat (6 * bp) @(negedge clk);
    rx_in = 1'b1;
    repeat (2 * bp) @(negedge clk);
    rx_en = 1'b1;
    repeat (bp) @(negedge clk);
    chk("abort no word", 32'(got_q.size()), 32'd0);
    send_line(8'hC3, 4'b0001, 1, 0);
    expect_word("after abort", 8'hC3, 1'b0, 1'b0, lat(0, 1));

    // Reset mid-DATA clears everything at once.
    rx_in = 1'b0;
    repeat (bp + 40) @(negedge clk);
    chk("pre-reset busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid rst busy", 32'(busy), 32'd0);
    chk("mid rst rx_data", 32'(rx_if.rx_data), 32'd0);
    chk("mid rst rx_valid", 32'(rx_if.rx_valid), 32'd0);
    chk("mid rst frame_err", 32'(rx_if.frame_err), 32'd0);
    chk("mid rst parity_err", 32'(rx_if.parity_err), 32'd0);
    chk("mid rst overrun", 32'(rx_if.overrun), 32'd0);
    repeat (3) @(negedge clk);
    rx_in = 1'b1;
    rst = 1'b1;
    repeat (3 * bp) @(negedge clk);
    chk("post rst busy", 32'(busy), 32'd0);
    chk("post rst no word", 32'(got_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
